aes_decipher_core: RTL
======================

// Module: aes_decipher_core
// PURPOSE
//  Parametrised AES inverse-cipher datapath (FIPS-197 InvCipher) for 128- and 256-bit keys.
//  Runtime key-length select; configurable InvSubBytes lane count to trade area for latency.
//  Adds abort and a one-cycle done strobe. Sits under the AES core wrapper, beside the key
//  expansion block, which serves round keys combinationally from the round index.
// PARAMETERS
//  SBOX_LANES  1  32-bit InvS-box words processed per cycle; legal values 1, 2, 4
//  KEY256_EN   1  1 = keylen input honoured; 0 = keylen ignored, always 128-bit
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  reset      in   1    one clock; reset is synchronous and active-high
//  next       in   1    start request; sampled only in IDLE
//  abort      in   1    cancel the current operation
//  keylen     in   1    0 = AES-128 (NR=10), 1 = AES-256 (NR=14); sampled at accept
//  round_key  in   128  round key for index `round`; valid same cycle
//  block      in   128  ciphertext; sampled in INIT cycle only
//  round      out  4    current round-key index requested from key expansion
//  new_block  out  128  state register; holds plaintext after done
//  ready      out  1    1 = idle, may accept next
//  done       out  1    one-cycle pulse when new_block becomes valid plaintext
// BEHAVIOUR
//  Reset values: round=0, new_block=0, ready=1, done=0. Internal state: FSM=IDLE, word ctr=0, keylen_reg=0.
//  S = 4/SBOX_LANES words-groups per round; NR latched from keylen on accept.
//  FSM states: IDLE, INIT, SBOX, MAIN.
//  IDLE: next=1 & abort=0 -> round<=NR, ready<=0, go INIT. next while not IDLE is ignored.
//  INIT: state <= InvShiftRows(block ^ round_key[NR]); group ctr<=0; go SBOX.
//  SBOX: InvSubBytes on words [g*L .. g*L+L-1] (word0 = bits 127:96); ctr++.
//   - On last group (ctr==S-1): round<=round-1; go MAIN. ctr wraps to 0.
//  MAIN: round>0 -> state <= InvShiftRows(InvMixColumns(state ^ round_key)); go SBOX.
//   - round==0 -> state <= state ^ round_key; ready<=1; done<=1 for one cycle; go IDLE.
//  Key indices used in order: NR, NR-1, ..., 0; each used exactly once.
//  Latency: next sampled in cycle 0 -> ready/done observed high in cycle NR*(S+1)+2.
//   - AES-128: 52 (L=1), 32 (L=2), 22 (L=4); AES-256: 72, 44, 30.
//  abort=1 in INIT/SBOX/MAIN: next edge -> IDLE, ready=1, done=0, new_block=0, round=0.
//  abort=1 in IDLE: no effect; abort & next same IDLE cycle: abort wins, no start.
//  abort coinciding with final MAIN: abort wins; no done pulse; new_block=0.
//  reset asserted mid-operation: all registers return to reset values next edge.
//  new_block is stable between done and next accept; it changes only from INIT onward.
//  KEY256_EN=0: keylen treated as 0; round never exceeds 10.
//  SBOX_LANES outside {1,2,4}: elaboration error.
// TESTING
//  T1 FIPS-197 C.1: AES-128 key 000102..0f, block 69c4e0d86a7b0430d8cdb78070b4c55a
//     -> new_block 00112233445566778899aabbccddeeff, done at cycle 52 (L=1).
//  T2 FIPS-197 C.3: keylen=1, key 000102..1f, block 8ea2b7ca516745bfeafc49904b496089
//     -> new_block 00112233445566778899aabbccddeeff, done at cycle 72 (L=1), 30 (L=4).
//  T3 Round-index trace: capture `round` in each INIT/MAIN cycle, AES-128
//     -> sequence 10,9,...,1,0, each exactly once.
//  T4 abort during SBOX of round 5 -> next cycle ready=1, new_block=0, no done;
//     immediate T1 restart gives the correct plaintext.
//  T5 next held high throughout an operation -> single accept; back-to-back start
//     the cycle after done; both results correct.
//  T6 reset pulse at cycle 20 -> ready=1, round=0, new_block=0;
//     abort+next in same IDLE cycle -> no start.

Source files
------------

// File: rtl/aes_decipher_core.sv
// AES inverse cipher datapath (AES-128/AES-256) with a configurable number of InvS-box lanes.
// Round keys come combinationally from the key expansion block, indexed by round_o.
//
// state | meaning
// IDLE  | ready for a new block; new_block_o holds the last plaintext
// INIT  | initial AddRoundKey with key NR, then InvShiftRows
// SBOX  | InvSubBytes on one group of SBOX_LANES words per cycle
// MAIN  | AddRoundKey, then InvMixColumns and InvShiftRows (final round: AddRoundKey only)
module aes_decipher_core #(
  parameter int SBOX_LANES = 1,
  parameter bit KEY256_EN  = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         next_i,
  input  logic         abort_i,
  input  logic         keylen_i,
  input  logic [127:0] round_key_i,
  input  logic [127:0] block_i,
  output logic [3:0]   round_o,
  output logic [127:0] new_block_o,
  output logic         ready_o,
  output logic         done_o
);

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
    $error("aes_decipher_core: SBOX_LANES must be 1, 2 or 4");
  end

  localparam int         GROUPS   = 4 / SBOX_LANES;
  localparam logic [1:0] LAST_GRP = 2'(GROUPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_SBOX = 2'd2;
  localparam logic [1:0] ST_MAIN = 2'd3;

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [1:0]   ctr_q, ctr_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TAB[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  // Byte 4*c+r sits in column c, row r; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    ctr_d   = ctr_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (next_i && !abort_i) begin
          round_d = (KEY256_EN && keylen_i) ? 4'd14 : 4'd10;
          ready_d = 1'b0;
          fsm_d   = ST_INIT;
        end
      end
      ST_INIT: begin
        state_d = inv_shift_rows(block_i ^ round_key_i);
        ctr_d   = 2'd0;
        fsm_d   = ST_SBOX;
      end
      ST_SBOX: begin
        // Only the selected group of words passes through the lane S-boxes.
        for (int k = 0; k < SBOX_LANES; k++) begin
          state_d[127 - 32*(int'(ctr_q)*SBOX_LANES + k) -: 32] =
            inv_sub_word(state_q[127 - 32*(int'(ctr_q)*SBOX_LANES + k) -: 32]);
        end
        if (ctr_q == LAST_GRP) begin
          ctr_d   = 2'd0;
          round_d = round_q - 4'd1;
          fsm_d   = ST_MAIN;
        end else begin
          ctr_d = ctr_q + 2'd1;
        end
      end
      default: begin
        if (round_q != 4'd0) begin
          state_d = inv_shift_rows(inv_mix_columns(state_q ^ round_key_i));
          fsm_d   = ST_SBOX;
        end else begin
          state_d = state_q ^ round_key_i;
          ready_d = 1'b1;
          done_d  = 1'b1;
          fsm_d   = ST_IDLE;
        end
      end
    endcase
    // Abort outranks everything, including the final round's done pulse.
    if (abort_i && fsm_q != ST_IDLE) begin
      fsm_d   = ST_IDLE;
      round_d = 4'd0;
      state_d = '0;
      ctr_d   = 2'd0;
      ready_d = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      ctr_q   <= 2'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ctr_q   <= ctr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign round_o     = round_q;
  assign new_block_o = state_q;
  assign ready_o     = ready_q;
  assign done_o      = done_q;

endmodule
